// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared constants for the APB timer register core: register map,
//            TCR field positions, reset values, default prescale limit and
//            small helpers used by the register core and counter engine.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Register map (byte addresses)
    localparam logic [11:0] c_addr_tcr   = 12'h000;
    localparam logic [11:0] c_addr_tdr0  = 12'h004;
    localparam logic [11:0] c_addr_tdr1  = 12'h008;
    localparam logic [11:0] c_addr_tcmp0 = 12'h00C;
    localparam logic [11:0] c_addr_tcmp1 = 12'h010;
    localparam logic [11:0] c_addr_tier  = 12'h014;
    localparam logic [11:0] c_addr_tisr  = 12'h018;

    // TCR field positions
    localparam int c_tcr_en_bit       = 0;
    localparam int c_tcr_div_en_bit   = 1;
    localparam int c_tcr_div_val_lsb  = 8;
    localparam int c_tcr_div_val_msb  = 11;

    // Largest legal div_val (prescale ratio 2**div_val)
    localparam int unsigned c_div_max_default = 8;

    typedef struct packed {
        logic [3:0] div_val;
        logic       div_en;
        logic       timer_en;
    } tcr_t;

    localparam tcr_t        c_tcr_rst  = '{div_val: 4'd1, div_en: 1'b0, timer_en: 1'b0};
    localparam logic [63:0] c_tcmp_rst = '1;

    // Replace the bytes selected by strb, keep the rest of old_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Terminal prescaler value 2**div_val - 1; div_val=8 gives 255.
    function automatic logic [7:0] div_terminal(input logic [3:0] div_val);
        return 8'((9'd1 << div_val) - 9'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_cnt64.sv
`default_nettype none
// ============================================================================
// Module   : timer_cnt64
// Purpose  : Prescaler plus 64-bit up-counter with independent load of the
//            low and high words. A loaded word takes the software value; the
//            other word still follows the increment (carry computed from the
//            pre-load value).
// Ports    : clk_i, rst_i (async, active-high)
//            timer_en_i, div_en_i, div_val_i : current TCR fields
//            halt_i                          : freeze prescaler and counter
//            ld0_i/ld0_val_i, ld1_i/ld1_val_i: per-word software load
//            cnt_o                           : current 64-bit count
// Revision : 1.0 - initial release
// ============================================================================
module timer_cnt64
    import timer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        timer_en_i,
    input  logic        div_en_i,
    input  logic [3:0]  div_val_i,
    input  logic        halt_i,
    input  logic        ld0_i,
    input  logic [31:0] ld0_val_i,
    input  logic        ld1_i,
    input  logic [31:0] ld1_val_i,
    output logic [63:0] cnt_o
);

    logic [7:0]  int_cnt_q, int_cnt_d;
    logic [63:0] cnt_q, cnt_d, cnt_inc;
    logic        tick;

    // Prescaler: the internal count is only meaningful while the timer runs
    // with division enabled; otherwise it is held at zero so a re-enable
    // always starts a full prescale period.
    always_comb begin
        tick      = 1'b0;
        int_cnt_d = int_cnt_q;
        if (!timer_en_i || !div_en_i) begin
            int_cnt_d = '0;
            tick      = timer_en_i && !halt_i;
        end else if (!halt_i) begin
            if (int_cnt_q == div_terminal(div_val_i)) begin
                tick      = 1'b1;
                int_cnt_d = '0;
            end else begin
                int_cnt_d = int_cnt_q + 8'd1;
            end
        end
    end

    // Software load overrides only its own word; no carry is generated from
    // a freshly loaded low word.
    always_comb begin
        cnt_inc = cnt_q + 64'(tick);
        cnt_d   = cnt_inc;
        if (ld0_i) begin
            cnt_d[31:0] = ld0_val_i;
        end
        if (ld1_i) begin
            cnt_d[63:32] = ld1_val_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            int_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            int_cnt_q <= int_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/timer_reg_core.sv
`default_nettype none
// ============================================================================
// Module   : timer_reg_core
// Purpose  : Register file, address decode, read mux and interrupt logic of
//            the APB timer. Holds TCR, TCMP0/1, TIER, TISR; TDR0/1 live in
//            the timer_cnt64 counter engine.
// Ports    : sys_clk, sys_rst (async, active-high)
//            w_en, r_en          : single-cycle strobes from the APB slave
//            tim_paddr/pwdata/pstrb : address, write data, byte strobes
//            tim_prdata          : combinational read data (0 when r_en=0)
//            tim_int             : level interrupt = TISR.int_st & TIER.int_en
//            dbg_mode            : debug halt (only with TIMER_HALT_EN)
// Config   : TIMER_HALT_EN - adds dbg_mode, which freezes prescaler and count.
// Revision : 1.0 - initial release
// ============================================================================
module timer_reg_core
    import timer_pkg::*;
#(
    parameter int unsigned DIV_MAX = c_div_max_default
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        w_en,
    input  logic        r_en,
    input  logic [11:0] tim_paddr,
    input  logic [31:0] tim_pwdata,
    input  logic [3:0]  tim_pstrb,
    output logic [31:0] tim_prdata,
`ifdef TIMER_HALT_EN
    input  logic        dbg_mode,
`endif
    output logic        tim_int
);

    localparam logic [3:0] c_div_max = DIV_MAX[3:0];

    tcr_t        tcr_q, tcr_d, tcr_cand;
    logic [63:0] tcmp_q, tcmp_d;
    logic        tier_q, tier_d;
    logic        tisr_q, tisr_d;
    logic [63:0] cnt;
    logic [31:0] tcr_word;
    logic [31:0] tdr0_wval, tdr1_wval;
    logic        tcr_ok, match, halt;
    logic        wr_tcr, wr_tdr0, wr_tdr1, wr_tcmp0, wr_tcmp1, wr_tier, wr_tisr;

`ifdef TIMER_HALT_EN
    assign halt = dbg_mode;
`else
    assign halt = 1'b0;
`endif

    assign wr_tcr   = w_en && (tim_paddr == c_addr_tcr);
    assign wr_tdr0  = w_en && (tim_paddr == c_addr_tdr0);
    assign wr_tdr1  = w_en && (tim_paddr == c_addr_tdr1);
    assign wr_tcmp0 = w_en && (tim_paddr == c_addr_tcmp0);
    assign wr_tcmp1 = w_en && (tim_paddr == c_addr_tcmp1);
    assign wr_tier  = w_en && (tim_paddr == c_addr_tier);
    assign wr_tisr  = w_en && (tim_paddr == c_addr_tisr);

    assign tcr_word  = {20'd0, tcr_q.div_val, 6'd0, tcr_q.div_en, tcr_q.timer_en};
    assign tdr0_wval = byte_merge(cnt[31:0],  tim_pwdata, tim_pstrb);
    assign tdr1_wval = byte_merge(cnt[63:32], tim_pwdata, tim_pstrb);
    assign match     = (cnt == tcmp_q);

    // Candidate TCR after byte strobes. The write is all-or-nothing: an
    // out-of-range divider, or any divider change while running, drops the
    // whole write including timer_en.
    always_comb begin
        tcr_cand = tcr_q;
        if (tim_pstrb[0]) begin
            tcr_cand.timer_en = tim_pwdata[c_tcr_en_bit];
            tcr_cand.div_en   = tim_pwdata[c_tcr_div_en_bit];
        end
        if (tim_pstrb[1]) begin
            tcr_cand.div_val = tim_pwdata[c_tcr_div_val_msb:c_tcr_div_val_lsb];
        end
        tcr_ok = (tcr_cand.div_val <= c_div_max) &&
                 !(tcr_q.timer_en && ((tcr_cand.div_en  != tcr_q.div_en) ||
                                      (tcr_cand.div_val != tcr_q.div_val)));
    end

    always_comb begin
        tcr_d  = tcr_q;
        tcmp_d = tcmp_q;
        tier_d = tier_q;
        tisr_d = tisr_q;
        if (wr_tcr && tcr_ok) begin
            tcr_d = tcr_cand;
        end
        if (wr_tcmp0) begin
            tcmp_d[31:0] = byte_merge(tcmp_q[31:0], tim_pwdata, tim_pstrb);
        end
        if (wr_tcmp1) begin
            tcmp_d[63:32] = byte_merge(tcmp_q[63:32], tim_pwdata, tim_pstrb);
        end
        if (wr_tier && tim_pstrb[0]) begin
            tier_d = tim_pwdata[0];
        end
        if (wr_tisr && tim_pstrb[0] && tim_pwdata[0]) begin
            tisr_d = 1'b0;
        end
        // A match in the same cycle as a clear keeps the status set.
        if (match) begin
            tisr_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tcr_q  <= c_tcr_rst;
            tcmp_q <= c_tcmp_rst;
            tier_q <= 1'b0;
            tisr_q <= 1'b0;
        end else begin
            tcr_q  <= tcr_d;
            tcmp_q <= tcmp_d;
            tier_q <= tier_d;
            tisr_q <= tisr_d;
        end
    end

    timer_cnt64 u_cnt (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .timer_en_i (tcr_q.timer_en),
        .div_en_i   (tcr_q.div_en),
        .div_val_i  (tcr_q.div_val),
        .halt_i     (halt),
        .ld0_i      (wr_tdr0),
        .ld0_val_i  (tdr0_wval),
        .ld1_i      (wr_tdr1),
        .ld1_val_i  (tdr1_wval),
        .cnt_o      (cnt)
    );

    always_comb begin
        tim_prdata = '0;
        if (r_en) begin
            case (tim_paddr)
                c_addr_tcr:   tim_prdata = tcr_word;
                c_addr_tdr0:  tim_prdata = cnt[31:0];
                c_addr_tdr1:  tim_prdata = cnt[63:32];
                c_addr_tcmp0: tim_prdata = tcmp_q[31:0];
                c_addr_tcmp1: tim_prdata = tcmp_q[63:32];
                c_addr_tier:  tim_prdata = {31'd0, tier_q};
                c_addr_tisr:  tim_prdata = {31'd0, tisr_q};
                default:      tim_prdata = '0;
            endcase
        end
    end

    assign tim_int = tisr_q & tier_q;

endmodule
`default_nettype wire
